// File: rtl/store_commit_drainer_if.sv
// store_commit_drainer_if: commit, store-queue head and DCache write port bundle
// master: drainer side (drives SQ read index, DCache request, SQ release, busy)
// slave : environment side (commit stage, store queue, DCache)
interface store_commit_drainer_if #(
  parameter int SQ_DEPTH = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int ADDR_WIDTH = 32
);
  logic commitStore;
  logic [$clog2(COMMIT_WIDTH+1)-1:0] commitStoreNum;
  logic [$clog2(SQ_DEPTH)-1:0] retiredStoreQueuePtr;
  logic [ADDR_WIDTH-4:0] retiredStoreLSQ_BlockAddr;
  logic [63:0] retiredStoreData;
  logic [7:0] retiredStoreByteWE;
  logic retiredStoreCondEnabled;
  logic dcWriteReq;
  logic dcWriteReqAck;
  logic dcWriteBusy;
  logic dcWriteHit;
  logic [ADDR_WIDTH-1:0] dcWriteAddr;
  logic [63:0] dcWriteData;
  logic [7:0] dcWriteByteWE;
  logic releaseStoreQueueHead;
  logic [$clog2(COMMIT_WIDTH+1)-1:0] releaseStoreQueueHeadEntryNum;
  logic busyInRecovery;
  modport master (
    input commitStore, commitStoreNum, retiredStoreLSQ_BlockAddr, retiredStoreData,
          retiredStoreByteWE, retiredStoreCondEnabled, dcWriteReqAck, dcWriteBusy, dcWriteHit,
    output retiredStoreQueuePtr, dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
           releaseStoreQueueHead, releaseStoreQueueHeadEntryNum, busyInRecovery
  );
  modport slave (
    output commitStore, commitStoreNum, retiredStoreLSQ_BlockAddr, retiredStoreData,
           retiredStoreByteWE, retiredStoreCondEnabled, dcWriteReqAck, dcWriteBusy, dcWriteHit,
    input retiredStoreQueuePtr, dcWriteReq, dcWriteAddr, dcWriteData, dcWriteByteWE,
          releaseStoreQueueHead, releaseStoreQueueHeadEntryNum, busyInRecovery
  );
endinterface

// File: rtl/store_commit_drainer.sv
// store_commit_drainer: drains committed stores from the SQ head into the DCache write port
// clk  : clock
// rst  : asynchronous active-low reset
// bus  : master side of store_commit_drainer_if (commit count in, SQ head entry in,
//        SQ read index / release out, DCache write request out with ack/busy/hit in,
//        busyInRecovery out)
module store_commit_drainer #(
  parameter int SQ_DEPTH = 16,
  parameter int COMMIT_WIDTH = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int RETRY_DELAY = 4
) (
  input logic clk,
  input logic rst,
  store_commit_drainer_if.master bus
);
  localparam int HW = $clog2(SQ_DEPTH);
  localparam int PW = $clog2(SQ_DEPTH+1);
  localparam int PW1 = PW + 1;
  localparam int NW = $clog2(COMMIT_WIDTH+1);
  typedef enum logic [1:0] {IDLE, REQ, TAG, RETRY} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [HW-1:0] head_q, head_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [7:0] we_q, we_d;
  logic rel;
  logic [PW:0] sum;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d = we_q;
    rel = 1'b0;
    case (state_q)
      IDLE: if (pend_q != '0) begin
        if (!bus.retiredStoreCondEnabled) rel = 1'b1;
        else if (!bus.dcWriteBusy) begin
          addr_d = {bus.retiredStoreLSQ_BlockAddr, 3'b000};
          data_d = bus.retiredStoreData;
          we_d = bus.retiredStoreByteWE;
          state_d = REQ;
        end
      end
      REQ: state_d = bus.dcWriteReqAck ? TAG : REQ;
      TAG: begin
        rel = bus.dcWriteHit;
        state_d = bus.dcWriteHit ? IDLE : RETRY;
        cnt_d = bus.dcWriteHit ? cnt_q : 4'(RETRY_DELAY);
      end
      RETRY: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? REQ : RETRY;
      end
      default: state_d = IDLE;
    endcase
  end
  // widened by one bit so an over-commit is visible to the assertion instead of wrapping
  assign sum = {1'b0, pend_q} + PW1'(bus.commitStore ? bus.commitStoreNum : NW'(0)) - PW1'(rel);
  assign pend_d = sum[PW-1:0];
  assign head_d = rel ? ((head_q == HW'(SQ_DEPTH-1)) ? '0 : head_q + 1'b1) : head_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      head_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      head_q <= head_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
    end
  end
  always_ff @(posedge clk) if (rst) assert (sum <= PW1'(SQ_DEPTH));
  assign bus.retiredStoreQueuePtr = head_q;
  assign bus.dcWriteReq = (state_q == REQ);
  assign bus.dcWriteAddr = addr_q;
  assign bus.dcWriteData = data_q;
  assign bus.dcWriteByteWE = we_q;
  assign bus.releaseStoreQueueHead = rel;
  assign bus.releaseStoreQueueHeadEntryNum = NW'(rel);
  assign bus.busyInRecovery = (pend_q != '0);
endmodule
